// File: rtl/vga_sdram_prefetch_cache_pkg.sv
// vga_pkg: shared definitions for the VGA SDRAM prefetch cache.
//   fill_state_t  - line fill FSM states (IDLE, REQ, DATA)
//   PIX_8BPP / PIX_16BPP - pixel_mode encodings
//   line_words()  - 32-bit words per cache line
//   tag_width()   - tag bits left above the line offset
package vga_pkg;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_REQ,
    FILL_DATA
  } fill_state_t;

  localparam logic PIX_8BPP  = 1'b0;
  localparam logic PIX_16BPP = 1'b1;

  function automatic int line_words(input int line_bytes);
    return line_bytes / 4;
  endfunction

  function automatic int tag_width(input int addr_w, input int line_bytes);
    return addr_w - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/vga_sdram_prefetch_cache_if.sv
// SDRAM burst read bus between the VGA cache and the SDRAM controller.
//   vga_sdram_req      - burst request, held until ack (cache -> controller)
//   vga_sdram_addr     - line-aligned burst byte address (cache -> controller)
//   vga_sdram_ack      - request accepted (controller -> cache)
//   vga_sdram_rdata    - burst data word (controller -> cache)
//   vga_sdram_rdvalid  - rdata valid (controller -> cache)
//   vga_sdram_complete - burst finished (controller -> cache)
// Modports: master = cache side, slave = controller side.
interface vga_sdram_prefetch_cache_if #(
  parameter int ADDR_W = 26
);
  logic              vga_sdram_req;
  logic [ADDR_W-1:0] vga_sdram_addr;
  logic              vga_sdram_ack;
  logic [31:0]       vga_sdram_rdata;
  logic              vga_sdram_rdvalid;
  logic              vga_sdram_complete;

  modport master (
    output vga_sdram_req, vga_sdram_addr,
    input  vga_sdram_ack, vga_sdram_rdata, vga_sdram_rdvalid, vga_sdram_complete
  );

  modport slave (
    input  vga_sdram_req, vga_sdram_addr,
    output vga_sdram_ack, vga_sdram_rdata, vga_sdram_rdvalid, vga_sdram_complete
  );
endinterface

// File: rtl/vga_sdram_prefetch_cache_line_buffer.sv
// vga_line_buffer: data storage for all cache lines, DEPTH x 32.
//   clk, reset    - clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata - single write port
//   re/raddr      - read request; rdata updates on the next edge when re is high
//   rdata         - registered read data
module vga_line_buffer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array has no reset; line valid bits guard every read,
  // and leaving it out keeps the array mappable onto RAM.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_sdram_prefetch_cache.sv
// vga_sdram_prefetch_cache: fully associative multi-line read cache between
// the VGA pixel pipeline and the SDRAM controller, round-robin replacement,
// one outstanding burst at a time.
//   clk, reset          - clock, asynchronous active-low reset
//   pixel_addr/_valid   - pixel byte address request
//   pixel_mode          - 0 = 8 bpp, 1 = 16 bpp (pixel_addr[0] ignored)
//   flush               - one-cycle pulse, invalidate all lines
//   pixel_data/_valid   - read data, one cycle after a hit request
//   stall               - request present but not a hit
//   sdram               - burst read bus (master modport)
// Optional feature: define VGA_SDRAM_PREFETCH_EN to fetch line T+1 ahead of a
// hit to line T while the fill engine is idle.
module vga_sdram_prefetch_cache
  import vga_pkg::*;
#(
  parameter int ADDR_W     = 26,
  parameter int LINE_BYTES = 64,
  parameter int NUM_LINES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pixel_addr,
  input  logic              pixel_addr_valid,
  input  logic              pixel_mode,
  input  logic              flush,
  output logic [15:0]       pixel_data,
  output logic              pixel_data_valid,
  output logic              stall,
  vga_sdram_prefetch_cache_if.master sdram
);

  localparam int LINE_WORDS = line_words(LINE_BYTES);
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int WORD_W     = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(NUM_LINES);
  localparam int TAG_W      = tag_width(ADDR_W, LINE_BYTES);

  fill_state_t           state, state_nx;
  logic [TAG_W-1:0]      tags [NUM_LINES];
  logic [NUM_LINES-1:0]  valid, hit_vec;
  logic [IDX_W-1:0]      rr_ptr, fill_idx, victim, hit_idx;
  logic [WORD_W-1:0]     wptr;
  logic                  drop, req_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [TAG_W-1:0]      req_tag, start_tag;
  logic                  hit, demand_miss, pf_start, start_fill, rd_en;
  logic [1:0]            sel_q;
  logic                  mode_q;
  logic [31:0]           rd_word;

  assign req_tag     = pixel_addr[ADDR_W-1:OFF_W];
  assign hit         = |hit_vec;
  assign demand_miss = pixel_addr_valid && !hit;
  assign stall       = pixel_addr_valid && !hit && reset;
  assign rd_en       = pixel_addr_valid && hit;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      hit_vec[i] = valid[i] && (tags[i] == req_tag);
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

`ifdef VGA_SDRAM_PREFETCH_EN
  logic [TAG_W-1:0] pf_tag;
  logic             pf_cached;

  // Next sequential line; the tag wraps at the top of the address space.
  assign pf_tag = req_tag + TAG_W'(1);

  always_comb begin
    pf_cached = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid[i] && (tags[i] == pf_tag)) pf_cached = 1'b1;
    end
  end

  assign pf_start  = pixel_addr_valid && hit && !pf_cached;
  assign start_tag = demand_miss ? req_tag : pf_tag;
  // A prefetch must not evict the line the scanout is reading right now.
  assign victim    = (pf_start && (rr_ptr == hit_idx)) ? rr_ptr + IDX_W'(1) : rr_ptr;
`else
  assign pf_start  = 1'b0;
  assign start_tag = req_tag;
  assign victim    = rr_ptr;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_fill = 1'b0;
    unique case (state)
      FILL_IDLE: begin
        // Demand misses win over prefetch because pf_start requires a hit.
        if (demand_miss || pf_start) begin
          start_fill = 1'b1;
          state_nx   = FILL_REQ;
        end
      end
      FILL_REQ:  if (sdram.vga_sdram_ack)      state_nx = FILL_DATA;
      FILL_DATA: if (sdram.vga_sdram_complete) state_nx = FILL_IDLE;
      default:                                 state_nx = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= '0;
      rr_ptr   <= '0;
      fill_idx <= '0;
      wptr     <= '0;
      drop     <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      if (start_fill) begin
        valid[victim] <= 1'b0;
        fill_idx      <= victim;
        wptr          <= '0;
        rr_ptr        <= victim + IDX_W'(1);
        req_q         <= 1'b1;
        addr_q        <= {start_tag, {OFF_W{1'b0}}};
      end
      if (state == FILL_REQ && sdram.vga_sdram_ack) req_q <= 1'b0;
      if (state == FILL_DATA && sdram.vga_sdram_rdvalid) wptr <= wptr + WORD_W'(1);
      if (state == FILL_DATA && sdram.vga_sdram_complete) begin
        if (!drop && !flush) valid[fill_idx] <= 1'b1;
        drop <= 1'b0;
      end
      // A flush mid-fill lets the burst run to completion but keeps the
      // line invalid; later assignments here override the ones above.
      if (flush) begin
        valid <= '0;
        if (state != FILL_IDLE && !(state == FILL_DATA && sdram.vga_sdram_complete))
          drop <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: a tag is only compared when its valid bit is set.
  always_ff @(posedge clk) begin
    if (start_fill) tags[victim] <= start_tag;
  end

  assign sdram.vga_sdram_req  = req_q;
  assign sdram.vga_sdram_addr = addr_q;

  vga_line_buffer #(
    .DEPTH (NUM_LINES * LINE_WORDS),
    .AW    (IDX_W + WORD_W)
  ) u_line_buffer (
    .clk   (clk),
    .reset (reset),
    .we    ((state == FILL_DATA) && sdram.vga_sdram_rdvalid),
    .waddr ({fill_idx, wptr}),
    .wdata (sdram.vga_sdram_rdata),
    .re    (rd_en),
    .raddr ({hit_idx, pixel_addr[OFF_W-1:2]}),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_data_valid <= 1'b0;
      sel_q            <= '0;
      mode_q           <= PIX_8BPP;
    end else begin
      pixel_data_valid <= rd_en;
      if (rd_en) begin
        sel_q  <= pixel_addr[1:0];
        mode_q <= pixel_mode;
      end
    end
  end

  // Byte lanes are little-endian: byte A sits in bits [8*A[1:0] +: 8].
  always_comb begin
    pixel_data = '0;
    if (mode_q == PIX_16BPP) pixel_data = sel_q[1] ? rd_word[31:16] : rd_word[15:0];
    else                     pixel_data = {8'h00, rd_word[{sel_q, 3'b000} +: 8]};
  end

endmodule

// File: tb/tb_vga_sdram_prefetch_cache.sv
// Scoreboard bench for vga_sdram_prefetch_cache: a behavioural SDRAM model
// serves bursts from a hashed memory image, expected pixels and burst
// addresses go into queues, and independent processes pop and compare.
// Hit/miss is predicted by a FIFO-of-lines model (round-robin over a fully
// associative cache evicts the oldest fill).
module tb_vga_sdram_prefetch_cache;
  import vga_pkg::*;

  localparam int ADDR_W     = 26;
  localparam int LINE_BYTES = 64;
  localparam int NUM_LINES  = 2;
  localparam int LINE_WORDS = LINE_BYTES / 4;
  localparam int TMO        = 400;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] pixel_addr = '0;
  logic              pixel_addr_valid = 1'b0;
  logic              pixel_mode = 1'b0;
  logic              flush = 1'b0;
  logic [15:0]       pixel_data;
  logic              pixel_data_valid;
  logic              stall;

  vga_sdram_prefetch_cache_if #(.ADDR_W(ADDR_W)) sd ();

  vga_sdram_prefetch_cache #(
    .ADDR_W     (ADDR_W),
    .LINE_BYTES (LINE_BYTES),
    .NUM_LINES  (NUM_LINES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pixel_addr       (pixel_addr),
    .pixel_addr_valid (pixel_addr_valid),
    .pixel_mode       (pixel_mode),
    .flush            (flush),
    .pixel_data       (pixel_data),
    .pixel_data_valid (pixel_data_valid),
    .stall            (stall),
    .sdram            (sd)
  );

  always #5 clk = ~clk;

  int                n_vec = 0;
  int                n_err = 0;
  logic [15:0]       exp_px [$];
  logic [ADDR_W-1:0] exp_req [$];
  int unsigned       model_lines [$];
  bit                chk_req;
  int                ctl_reqs = 0;
  int                ctl_words = 0;
  logic [ADDR_W-1:0] last_req = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: word 0x10 (bytes 0x40..0x43) holds 0x44332211, rest hashed.
  function automatic logic [31:0] mem_word(input int unsigned w);
    if (w == 32'h10) return 32'h44332211;
    return (w * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [7:0] mem_byte(input int unsigned b);
    logic [31:0] w;
    w = mem_word(b / 4);
    return w[8*(b%4) +: 8];
  endfunction

  function automatic logic [15:0] pixel_of(input int unsigned a, input logic m);
    int unsigned a0;
    a0 = a & 32'hFFFF_FFFE;
    if (m) return {mem_byte(a0 + 1), mem_byte(a0)};
    return {8'h00, mem_byte(a)};
  endfunction

  function automatic bit model_has(input int unsigned t);
    foreach (model_lines[i]) if (model_lines[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_fill(input int unsigned t);
    model_lines.push_back(t);
    if (model_lines.size() > NUM_LINES) void'(model_lines.pop_front());
  endtask

  task automatic do_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    model_lines.delete();
  endtask

  // One pixel read held until accepted. stall_exp: 0/1 expected stall,
  // 2 = predict from the line model, -1 = do not check stall.
  task automatic read_px(input int unsigned a, input logic m, input int stall_exp);
    int cyc;
    int e;
    int unsigned t;
    t = a / LINE_BYTES;
    @(posedge clk); #1;
    pixel_addr = ADDR_W'(a);
    pixel_mode = m;
    pixel_addr_valid = 1'b1;
    @(negedge clk);
    e = stall_exp;
    if (e == 2) e = model_has(t) ? 0 : 1;
    if (e >= 0) check("stall", 32'(stall), e);
    if (e == 1 && chk_req) begin
      exp_req.push_back(ADDR_W'(t * LINE_BYTES));
      model_fill(t);
    end
    cyc = 0;
    while (stall && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    if (stall) check("stall_timeout", 32'(stall), 0);
    else       exp_px.push_back(pixel_of(a, m));
    @(posedge clk); #1 pixel_addr_valid = 1'b0;
  endtask

  task automatic wait_reqs_above(input int r0);
    int cyc;
    cyc = 0;
    while (ctl_reqs <= r0 && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    if (ctl_reqs <= r0) check("req_timeout", 32'(ctl_reqs - r0), 1);
  endtask

  task automatic wait_words(input int n);
    int cyc;
    cyc = 0;
    while (ctl_words < n && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    if (ctl_words < n) check("words_timeout", 32'(ctl_words), n);
  endtask

  // SDRAM controller model: serves one burst; abandons it on reset.
  task automatic serve();
    logic [ADDR_W-1:0] a;
    bit both;
    a = sd.vga_sdram_addr;
    ctl_reqs++;
    ctl_words = 0;
    last_req = a;
    if (chk_req) begin
      if (exp_req.size() == 0) check("req_unexpected", 32'(sd.vga_sdram_req), 0);
      else                     check("req_addr", 32'(a), 32'(exp_req.pop_front()));
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      if (!reset) return;
    end
    sd.vga_sdram_ack = 1'b1;
    @(negedge clk);
    sd.vga_sdram_ack = 1'b0;
    if (!reset) return;
    check("req_drop", 32'(sd.vga_sdram_req), 0);
    both = 1'($urandom_range(0, 1));
    for (int w = 0; w < LINE_WORDS; w++) begin
      repeat ($urandom_range(0, 1)) begin
        @(negedge clk);
        if (!reset) return;
      end
      sd.vga_sdram_rdvalid = 1'b1;
      sd.vga_sdram_rdata   = mem_word(int'(a) / 4 + w);
      ctl_words++;
      if (w == LINE_WORDS - 1 && both) sd.vga_sdram_complete = 1'b1;
      @(negedge clk);
      sd.vga_sdram_rdvalid  = 1'b0;
      sd.vga_sdram_complete = 1'b0;
      if (!reset) return;
    end
    if (!both) begin
      sd.vga_sdram_complete = 1'b1;
      @(negedge clk);
      sd.vga_sdram_complete = 1'b0;
    end
  endtask

  initial begin
    sd.vga_sdram_ack      = 1'b0;
    sd.vga_sdram_rdata    = '0;
    sd.vga_sdram_rdvalid  = 1'b0;
    sd.vga_sdram_complete = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && sd.vga_sdram_req) serve();
    end
  end

  // Monitor: every presented pixel is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && pixel_data_valid) begin
        if (exp_px.size() == 0) check("px_unexpected", 32'(pixel_data_valid), 0);
        else                    check("pixel", 32'(pixel_data), 32'(exp_px.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int se;
    int r0;
    int cyc;
`ifdef VGA_SDRAM_PREFETCH_EN
    chk_req = 1'b0;
    se = -1;
`else
    chk_req = 1'b1;
    se = 2;
`endif
    // Reset state, with a request pending to show stall is gated by reset.
    pixel_addr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(sd.vga_sdram_req), 0);
    check("rst_addr", 32'(sd.vga_sdram_addr), 0);
    check("rst_pixel_data", 32'(pixel_data), 0);
    check("rst_pixel_valid", 32'(pixel_data_valid), 0);
    check("rst_stall", 32'(stall), 0);
    pixel_addr_valid = 1'b0;
    @(negedge clk) reset = 1'b1;

    // Cold 8 bpp read, then a 16 bpp hit on the preloaded word (0x4433).
    read_px(32'h40, PIX_8BPP, 1);
    read_px(32'h42, PIX_16BPP, se);

    // Round-robin eviction over three sequential lines.
    repeat (60) @(posedge clk);
    do_flush();
    read_px(32'h000, PIX_8BPP, se);
    read_px(32'h040, PIX_16BPP, se);
    read_px(32'h080, PIX_8BPP, se);
    read_px(32'h001, PIX_8BPP, se);
    read_px(32'h084, PIX_16BPP, se);

`ifdef VGA_SDRAM_PREFETCH_EN
    // Hit at 0x100 issues a prefetch of 0x140; a read of 0x140 during that
    // fill stalls and raises no extra request.
    repeat (60) @(posedge clk);
    do_flush();
    read_px(32'h100, PIX_8BPP, 1);
    r0 = ctl_reqs;
    wait_reqs_above(r0);
    check("pf_addr", 32'(last_req), 32'h140);
    read_px(32'h144, PIX_16BPP, 1);
    check("pf_no_dup_req", 32'(ctl_reqs - r0), 1);
`endif

    // Flush during DATA: the dropped fill leaves the line invalid, so the
    // held request refetches it.
    repeat (60) @(posedge clk);
    do_flush();
    @(posedge clk); #1;
    pixel_addr = ADDR_W'(32'h200);
    pixel_mode = PIX_8BPP;
    pixel_addr_valid = 1'b1;
    r0 = ctl_reqs;
    if (chk_req) begin
      exp_req.push_back(ADDR_W'(32'h200));
      exp_req.push_back(ADDR_W'(32'h200));
    end
    @(negedge clk);
    check("flush_stall", 32'(stall), 1);
    wait_reqs_above(r0);
    wait_words(4);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    cyc = 0;
    while (stall && cyc < 2 * TMO) begin
      @(negedge clk);
      cyc++;
    end
    check("flush_released", 32'(stall), 0);
    check("flush_refetch_reqs", 32'(ctl_reqs - r0), 2);
    if (!stall) exp_px.push_back(pixel_of(32'h200, PIX_8BPP));
    model_fill(32'h200 / LINE_BYTES);
    @(posedge clk); #1 pixel_addr_valid = 1'b0;

    // Randomised reads over six lines with occasional flushes.
    repeat (200) begin
      if ($urandom_range(0, 15) == 0) do_flush();
      read_px($urandom_range(0, 6 * LINE_BYTES - 1), 1'($urandom_range(0, 1)), se);
    end

    // Reset in the middle of a burst.
    repeat (60) @(posedge clk);
    @(posedge clk); #1;
    pixel_addr = ADDR_W'(32'h1000);
    pixel_addr_valid = 1'b1;
    r0 = ctl_reqs;
    if (chk_req && !model_has(32'h1000 / LINE_BYTES)) exp_req.push_back(ADDR_W'(32'h1000));
    wait_reqs_above(r0);
    wait_words(3);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    check("mid_rst_req", 32'(sd.vga_sdram_req), 0);
    check("mid_rst_addr", 32'(sd.vga_sdram_addr), 0);
    check("mid_rst_pixel_data", 32'(pixel_data), 0);
    check("mid_rst_pixel_valid", 32'(pixel_data_valid), 0);
    check("mid_rst_stall", 32'(stall), 0);
    pixel_addr_valid = 1'b0;
    model_lines.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    read_px(32'h40, PIX_8BPP, 1);

    repeat (10) @(posedge clk);
    check("px_queue_drained", 32'(exp_px.size()), 0);
    check("req_queue_drained", 32'(exp_req.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sdram_prefetch_cache.md
# vga_sdram_prefetch_cache

Multi-line read cache between the VGA pixel pipeline and the SDRAM controller, replacing the single-line VGA fetch buffer. It holds NUM_LINES lines in a fully associative cache with round-robin replacement and supports 8 bpp and 16 bpp pixel modes. With prefetch compiled in, it optionally fetches the sequentially next line ahead of the scanout. At most one SDRAM burst is outstanding at any time.

## Interface
- ADDR_W, 26, byte address width
- LINE_BYTES, 64, line size in bytes; power of 2, 16..256; LINE_WORDS = LINE_BYTES/4
- NUM_LINES, 2, line count; power of 2, 2..8
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- pixel_addr  in  ADDR_W  byte address of requested pixel
- pixel_addr_valid  in  1  request valid this cycle
- pixel_mode  in  1  0 = 8 bpp, 1 = 16 bpp; pixel_addr[0] ignored in 16 bpp
- flush  in  1  one-cycle pulse, invalidate all lines
- pixel_data  out  16  read data; 8 bpp uses [7:0] with [15:8] = 0; 16 bpp = {byte A+1, byte A}
- pixel_data_valid  out  1  pixel_data valid
- stall  out  1  combinational: pixel_addr_valid && !hit && reset
- vga_sdram_req  out  1  burst request, held until ack
- vga_sdram_addr  out  ADDR_W  line-aligned burst address
- vga_sdram_ack  in  1  controller accepted request
- vga_sdram_rdata  in  32  burst word
- vga_sdram_rdvalid  in  1  rdata valid
- vga_sdram_complete  in  1  burst finished

## Operation
- Per line: tag = addr[ADDR_W-1:log2(LINE_BYTES)], valid bit. Hit means valid && tag match.
- Fill FSM states: IDLE, REQ (req high, waiting for ack), DATA (collecting rdvalid words, waiting for complete).
- IDLE: on a demand miss, go to REQ with the demand line. Else, with the macro enabled, go to REQ with the prefetch candidate.
- Victim = line at round-robin pointer; its valid bit clears on REQ entry, tag loads, fill word pointer resets to 0, and the pointer advances.
- REQ: on ack, go to DATA; req drops the cycle after ack.
- DATA: each rdvalid writes line[victim][wptr]; wptr wraps modulo LINE_WORDS. On complete, set valid (unless dropped), then go to IDLE.
- A demand miss during REQ/DATA to a different line waits. It is issued the cycle after returning to IDLE, and takes priority over prefetch.
- A miss to the line currently being filled issues nothing; stall persists until valid.
- flush: all valid bits clear. An in-flight fill sets a drop flag, its data is still written, and complete does not set valid. The FSM finishes the burst normally, and no request is aborted.
- Complete with fewer than LINE_WORDS rdvalids still marks the line valid; burst length is the controller's contract.

## Timing
- Reset values: vga_sdram_req 0, vga_sdram_addr 0, pixel_data 0, pixel_data_valid 0, all valid 0, round-robin pointer 0, FSM IDLE, drop 0.
- Hit latency: pixel_data and pixel_data_valid registered one cycle after a hit request; pixel_data_valid = registered (pixel_addr_valid && hit).
- Miss: stall asserts in the same cycle; vga_sdram_req rises the next clock edge when the FSM is IDLE.
- Completion: valid is set on the edge where complete is seen; stall for that line drops the following cycle.
- A rdvalid and complete in the same cycle: the word is written and the line is validated.
- flush and complete in the same cycle: the line is not validated.
- Reset mid-burst: the FSM returns to IDLE immediately; the controller must be reset alongside.

## Configuration
- VGA_SDRAM_PREFETCH_EN defined: on any hit to line T, if line T+1 is neither cached nor being filled and the FSM is IDLE with no demand miss, a fetch of T+1 is issued.
- Prefetch victim selection skips the line currently hit; the tag wraps modulo the address space.
- VGA_SDRAM_PREFETCH_EN undefined: demand fetches only; the prefetch logic is absent.

## Structure
- Package vga_pkg: fill FSM state enum, pixel_mode encoding constants, and functions computing LINE_WORDS and tag width from the parameters.
- Sub-module vga_line_buffer: NUM_LINES*LINE_WORDS x 32 storage, one write port, one registered read port.
- Tag/valid compare, FSM and prefetch logic stay in the top module.

## Test plan
- Cold read at 0x000040, 8 bpp: stall high; req with addr 0x000040; after 16 words and complete, the next cycle yields pixel_data 0x00XX matching byte 0x40 with valid.
- 16 bpp read at 0x000042 with words preloaded as 0x44332211: pixel_data = 0x4433 one cycle after the request.
- NUM_LINES=2, lines 0x000, 0x040, 0x080 read in sequence: the 0x080 fill evicts line 0x000; a read of 0x000 then misses again.
- Prefetch enabled, hit at 0x000100: a req for 0x000140 is issued with no stall. A request to 0x000140 during DATA stalls until complete.
- flush pulsed during DATA of 0x000200: complete does not validate the line; the next read of 0x000200 issues a new req.
- reset asserted mid-burst: all outputs return to reset values asynchronously; after release, the first request misses.
